// File: rtl/seq_hit_window_counter_if.sv
// seq_hit_window_counter bus: window control in, detector bit in, status out.
// master drives the window request and det; slave is the counter.
interface seq_hit_window_counter_if #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 8
);
   logic             start;
   logic [WIN_W-1:0] win_len;
   logic [CNT_W-1:0] thresh;
   logic             det;
   logic [CNT_W-1:0] hit_cnt;
   logic             busy;
   logic             done;
   logic             alarm;

   modport master (
      output start, win_len, thresh, det,
      input  hit_cnt, busy, done, alarm
   );

   modport slave (
      input  start, win_len, thresh, det,
      output hit_cnt, busy, done, alarm
   );
endinterface

// File: rtl/seq_hit_window_counter.sv
// Counts detector hits over a programmable bit-clock window, sticky alarm.
// Define SEQ_HIT_EDGE_COUNT_EN to count only rising edges of det.
module seq_hit_window_counter #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   seq_hit_window_counter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_REPORT
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_thresh;
   logic [WIN_W-1:0] r_win_cnt;
   logic [WIN_W-1:0] r_win_len;
   logic             r_busy;
   logic             r_done;
   logic             r_alarm;

   logic             w_hit;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIN_W-1:0] w_win_nxt;
   logic             w_alarm_set;
   logic             w_accept;

   assign w_accept = (r_state == S_IDLE) && bus.start;

`ifdef SEQ_HIT_EDGE_COUNT_EN
   logic r_det_prev;

   // Previous in-window det sample, so a held-high det counts once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_det_prev <= 1'b0;
      end else if (w_accept) begin
         r_det_prev <= 1'b0;
      end else if (r_state == S_COUNT) begin
         r_det_prev <= bus.det;
      end
   end

   assign w_hit = bus.det & ~r_det_prev;
`else
   assign w_hit = bus.det;
`endif

   assign w_cnt_nxt = (w_hit && !(&r_hit_cnt))
                    ? r_hit_cnt + CNT_W'(1)
                    : r_hit_cnt;
   assign w_win_nxt = r_win_cnt + WIN_W'(1);
   assign w_alarm_set = (r_thresh != '0)
                     && (w_cnt_nxt >= r_thresh);

   // Window FSM; every status output is a register set on the edge
   // that enters the state it describes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_hit_cnt <= '0;
         r_thresh  <= '0;
         r_win_cnt <= '0;
         r_win_len <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_alarm   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               r_busy <= 1'b0;
               if (bus.start) begin
                  r_win_len <= bus.win_len;
                  r_thresh  <= bus.thresh;
                  r_hit_cnt <= '0;
                  r_alarm   <= 1'b0;
                  r_win_cnt <= '0;
                  if (bus.win_len != '0) begin
                     r_state <= S_COUNT;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_REPORT;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_COUNT: begin
               r_hit_cnt <= w_cnt_nxt;
               r_win_cnt <= w_win_nxt;
               if (w_alarm_set) begin
                  r_alarm <= 1'b1;
               end
               if (w_win_nxt == r_win_len) begin
                  r_state <= S_REPORT;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_REPORT: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hit_cnt = r_hit_cnt;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.alarm   = r_alarm;
endmodule

// File: tb/tb_seq_hit_window_counter.sv
// Scoreboard bench for seq_hit_window_counter (CNT_W=4, WIN_W=8).
// Expected window results are queued at start; a monitor checks them on done.
module tb_seq_hit_window_counter;
   localparam int CNT_W = 4;
   localparam int WIN_W = 8;

   typedef struct {
      int hit;
      int alarm;
      int cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   ncnt;
   int   checks;
   int   errors;
   exp_t q[$];

   seq_hit_window_counter_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

   seq_hit_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: counts falling edges and scores every done pulse.
   initial begin
      exp_t e;
      ncnt = 0;
      forever begin
         @(negedge clk);
         ncnt++;
         if (bus.done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               chk("done_cycle", ncnt, e.cyc);
               chk("final_hit_cnt", int'(bus.hit_cnt), e.hit);
               chk("final_alarm", int'(bus.alarm), e.alarm);
               chk("busy_at_done", int'(bus.busy), 0);
            end
         end else if (q.size() != 0 && q[0].cyc == ncnt) begin
            e = q.pop_front();
            chk("missing_done", 0, 1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   // One window: start, then det per sample from pat (bit i-1 = sample i).
   task automatic run_win(input string nm, input int w, input int t,
                          input logic [31:0] pat, input int extra,
                          input int start_at, input int exp_hit,
                          input int alarm_at);
      exp_t e;
      int   l;
      @(negedge clk);
      #1;
      bus.start   = 1'b1;
      bus.win_len = w[WIN_W-1:0];
      bus.thresh  = t[CNT_W-1:0];
      bus.det     = 1'b0;
      e.hit   = exp_hit;
      e.alarm = (alarm_at != 0) ? 1 : 0;
      e.cyc   = ncnt + 1 + w;
      q.push_back(e);
      l = w + extra;
      for (int i = 1; i <= l; i++) begin
         @(negedge clk);
         #1;
         if (i >= 2 && i - 1 <= w) begin
            chk({nm, "_busy"}, int'(bus.busy), (i - 1 < w) ? 1 : 0);
            chk({nm, "_alarm"}, int'(bus.alarm),
                (alarm_at != 0 && i - 1 >= alarm_at) ? 1 : 0);
         end
         bus.start = (i == start_at);
         bus.det   = pat[i-1];
      end
      @(negedge clk);
      #1;
      bus.start = 1'b0;
      bus.det   = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.win_len = '0;
      bus.thresh  = '0;
      bus.det     = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_hit_cnt", int'(bus.hit_cnt), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_alarm", int'(bus.alarm), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic: hits on 2,5,8; start in COUNT ignored.
      run_win("basic", 10, 3, 32'h0000_0092, 2, 3, 3, 8);
      // Boundary: hit on 4 counts, 5-7 fall in REPORT/IDLE;
      // start during REPORT is not queued.
      run_win("boundary", 4, 2, 32'h0000_0078, 4, 5, 1, 0);
`ifdef SEQ_HIT_EDGE_COUNT_EN
      run_win("satur", 20, 15, 32'h000F_FFFF, 2, 0, 1, 0);
`else
      run_win("satur", 20, 15, 32'h000F_FFFF, 2, 0, 15, 15);
`endif
      run_win("zero_win", 0, 1, 32'h0000_0003, 2, 0, 0, 0);
      run_win("zero_thr", 10, 0, 32'h0000_0155, 2, 0, 5, 0);
`ifdef SEQ_HIT_EDGE_COUNT_EN
      run_win("edge_mode", 8, 3, 32'h0000_0027, 2, 0, 2, 0);
`else
      run_win("edge_mode", 8, 3, 32'h0000_0027, 2, 0, 4, 3);
`endif

      // Asynchronous reset in the middle of a window.
      @(negedge clk);
      #1;
      bus.start   = 1'b1;
      bus.win_len = 8'd20;
      bus.thresh  = 4'd3;
      bus.det     = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         #1;
         bus.start = 1'b0;
         bus.det   = (i % 2 == 1);
      end
      @(negedge clk);
      #1;
      bus.det = 1'b0;
      chk("mid_hit_cnt", int'(bus.hit_cnt), 5);
      chk("mid_alarm", int'(bus.alarm), 1);
      chk("mid_busy", int'(bus.busy), 1);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_hit_cnt", int'(bus.hit_cnt), 0);
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_done", int'(bus.done), 0);
      chk("arst_alarm", int'(bus.alarm), 0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      repeat (25) @(negedge clk);
      #1;
      chk("post_rst_busy", int'(bus.busy), 0);

      // Fresh window after reset still works.
      run_win("after_rst", 3, 1, 32'h0000_0002, 2, 0, 1, 2);

      repeat (5) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
